// File: rtl/hist_multi_engine.sv
// Multi-channel frame histogram: per-channel bin RAMs with a 2-stage increment pipeline,
// frame-synchronous accumulation and valid/ready readout. Optional macro: HIST_SAT_EN.
module hist_multi_engine #(
  parameter int CH_NUM    = 3,
  parameter int BIN_BITS  = 5,
  parameter int CNT_WIDTH = 20
) (
  input  logic                          sys_clk_i,
  input  logic                          sys_rst_n_i,
  input  logic [CH_NUM*BIN_BITS-1:0]    bin_i,
  input  logic                          de_i,
  input  logic                          vsync_i,
  output logic                          hist_valid_o,
  input  logic                          hist_ready_i,
  output logic [BIN_BITS-1:0]           hist_bin_o,
  output logic [CH_NUM*CNT_WIDTH-1:0]   hist_data_o,
  output logic                          hist_last_o,
  output logic                          busy_o,
  output logic                          ovf_o
);

  localparam int BINS = 1 << BIN_BITS;

  localparam logic [2:0] ST_CLEAR = 3'd0;
  localparam logic [2:0] ST_WAIT  = 3'd1;
  localparam logic [2:0] ST_ACCUM = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_READ  = 3'd4;

  localparam logic [CNT_WIDTH-1:0] CNT_ONES = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [BIN_BITS-1:0]  BIN_LAST = '1;
  localparam logic [BIN_BITS-1:0]  BIN_ONE  = {{(BIN_BITS-1){1'b0}}, 1'b1};

  logic [2:0]           state;
  logic                 vsync_q;
  logic                 vsync_rise;
  logic [BIN_BITS-1:0]  clr_addr;
  logic [BIN_BITS-1:0]  rd_addr;
  logic                 drain_cnt;
  logic                 read_xfer;
  logic                 last_xfer;
  logic                 any_full;

  logic [BIN_BITS-1:0]  pix_bin [CH_NUM];
  logic                 p1_valid;
  logic [BIN_BITS-1:0]  p1_bin  [CH_NUM];
  logic [CNT_WIDTH-1:0] p1_rd   [CH_NUM];
  logic [CNT_WIDTH-1:0] wr_val  [CH_NUM];
  logic [CNT_WIDTH-1:0] mem     [CH_NUM][BINS];

  assign vsync_rise = vsync_i & ~vsync_q;
  assign read_xfer  = hist_valid_o & hist_ready_i;
  assign last_xfer  = read_xfer & hist_last_o;
  assign busy_o     = (state != ST_WAIT);

  always_comb begin
    for (int k = 0; k < CH_NUM; k++) begin
      pix_bin[k] = bin_i[k*BIN_BITS +: BIN_BITS];
    end
  end

  // Next count for the bin held in stage 1; the read value already carries any forwarded write.
  always_comb begin
    any_full = 1'b0;
    for (int k = 0; k < CH_NUM; k++) begin
`ifdef HIST_SAT_EN
      wr_val[k] = (p1_rd[k] == CNT_ONES) ? CNT_ONES : p1_rd[k] + CNT_ONE;
`else
      wr_val[k] = p1_rd[k] + CNT_ONE;
`endif
      if (p1_rd[k] == CNT_ONES) begin
        any_full = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      vsync_q <= 1'b0;
    end else begin
      vsync_q <= vsync_i;
    end
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      state     <= ST_CLEAR;
      clr_addr  <= '0;
      drain_cnt <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          clr_addr <= clr_addr + BIN_ONE;
          if (clr_addr == BIN_LAST) begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (vsync_rise) begin
            state <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (vsync_rise) begin
            state     <= ST_DRAIN;
            drain_cnt <= 1'b0;
          end
        end
        ST_DRAIN: begin
          drain_cnt <= 1'b1;
          if (drain_cnt) begin
            state <= ST_READ;
          end
        end
        ST_READ: begin
          if (last_xfer) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
          end
        end
        default: begin
          state    <= ST_CLEAR;
          clr_addr <= '0;
        end
      endcase
    end
  end

  // The frame-closing vsync cycle never launches a pixel, so DRAIN only sees the tail write.
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      p1_valid <= 1'b0;
      for (int k = 0; k < CH_NUM; k++) begin
        p1_bin[k] <= '0;
      end
    end else begin
      p1_valid <= (state == ST_ACCUM) && de_i && !vsync_rise;
      for (int k = 0; k < CH_NUM; k++) begin
        p1_bin[k] <= pix_bin[k];
      end
    end
  end

  // Bin storage has no reset; CLEAR sweeps it after every reset and every readout.
  always_ff @(posedge sys_clk_i) begin
    for (int k = 0; k < CH_NUM; k++) begin
      if (state == ST_CLEAR) begin
        mem[k][clr_addr] <= '0;
      end else if (p1_valid) begin
        mem[k][p1_bin[k]] <= wr_val[k];
      end
      if (p1_valid && (p1_bin[k] == pix_bin[k])) begin
        p1_rd[k] <= wr_val[k];
      end else begin
        p1_rd[k] <= mem[k][pix_bin[k]];
      end
    end
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      ovf_o <= 1'b0;
    end else if (last_xfer) begin
      ovf_o <= 1'b0;
    end else if (p1_valid && any_full) begin
      ovf_o <= 1'b1;
    end
  end

  // Output register reloads only when empty or when the current word is accepted.
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      rd_addr      <= '0;
      hist_valid_o <= 1'b0;
      hist_last_o  <= 1'b0;
      hist_bin_o   <= '0;
      hist_data_o  <= '0;
    end else if (state == ST_READ) begin
      if (last_xfer) begin
        hist_valid_o <= 1'b0;
        hist_last_o  <= 1'b0;
        rd_addr      <= '0;
      end else if (!hist_valid_o || hist_ready_i) begin
        hist_valid_o <= 1'b1;
        hist_bin_o   <= rd_addr;
        hist_last_o  <= (rd_addr == BIN_LAST);
        rd_addr      <= rd_addr + BIN_ONE;
        for (int k = 0; k < CH_NUM; k++) begin
          hist_data_o[k*CNT_WIDTH +: CNT_WIDTH] <= mem[k][rd_addr];
        end
      end
    end else begin
      hist_valid_o <= 1'b0;
      hist_last_o  <= 1'b0;
      rd_addr      <= '0;
    end
  end

endmodule

// File: tb/tb_hist_multi_engine.sv
// Bench for hist_multi_engine: a default-width instance plus a 4-bit-counter instance fed the same
// stimulus, checked against per-frame bin counts tallied from the driven pixels.
module tb_hist_multi_engine;

  localparam int CH = 3;
  localparam int BB = 5;
  localparam int CW = 20;
  localparam int SW = 4;
  localparam int NB = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [CH*BB-1:0]  bin = '0;
  logic              de = 1'b0;
  logic              vsync = 1'b0;
  logic              ready = 1'b1;

  logic              valid_m, last_m, busy_m, ovf_m;
  logic [BB-1:0]     bin_m;
  logic [CH*CW-1:0]  data_m;
  logic              valid_s, last_s, busy_s, ovf_s;
  logic [BB-1:0]     bin_s;
  logic [CH*SW-1:0]  data_s;

  int checks = 0;
  int errors = 0;
  int model [CH][NB];
  logic [CH*BB-1:0] q_bin [$];
  bit               q_de  [$];

  hist_multi_engine #(.CH_NUM(CH), .BIN_BITS(BB), .CNT_WIDTH(CW)) dut_main (
    .sys_clk_i(clk), .sys_rst_n_i(rst_n), .bin_i(bin), .de_i(de), .vsync_i(vsync),
    .hist_valid_o(valid_m), .hist_ready_i(ready), .hist_bin_o(bin_m), .hist_data_o(data_m),
    .hist_last_o(last_m), .busy_o(busy_m), .ovf_o(ovf_m)
  );

  hist_multi_engine #(.CH_NUM(CH), .BIN_BITS(BB), .CNT_WIDTH(SW)) dut_small (
    .sys_clk_i(clk), .sys_rst_n_i(rst_n), .bin_i(bin), .de_i(de), .vsync_i(vsync),
    .hist_valid_o(valid_s), .hist_ready_i(ready), .hist_bin_o(bin_s), .hist_data_o(data_s),
    .hist_last_o(last_s), .busy_o(busy_s), .ovf_o(ovf_s)
  );

  always #5 clk = ~clk;

  function automatic int exp_count(input int c, input int w);
    int full;
    full = (1 << w) - 1;
`ifdef HIST_SAT_EN
    return (c > full) ? full : c;
`else
    return c % (1 << w);
`endif
  endfunction

  function automatic bit exp_ovf(input int w);
    bit o;
    o = 1'b0;
    for (int k = 0; k < CH; k++)
      for (int b = 0; b < NB; b++)
        if (model[k][b] >= (1 << w)) o = 1'b1;
    return o;
  endfunction

  function automatic logic [CH*BB-1:0] pack3(input int b0, input int b1, input int b2);
    logic [BB-1:0] x0, x1, x2;
    x0 = BB'(b0);
    x1 = BB'(b1);
    x2 = BB'(b2);
    return {x2, x1, x0};
  endfunction

  task automatic wait_idle();
    int cyc;
    cyc = 0;
    while (busy_m !== 1'b0 && cyc < 200) begin
      de  = 1'($urandom_range(0, 1));
      bin = CH*BB'($urandom);
      @(negedge clk);
      cyc++;
    end
    de = 1'b0;
    checks++;
    if (busy_m !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wait_idle: busy=%b after %0d cycles, required 0", busy_m, cyc);
    end
  endtask

  task automatic readout(input int mode, input bit noise);
    int idx, cyc;
    bit prev_stall, r;
    logic [BB-1:0]    pb;
    logic [CH*CW-1:0] pd;
    idx = 0; cyc = 0; prev_stall = 1'b0; pb = '0; pd = '0;
    while (idx < NB && cyc < 400) begin
      if (prev_stall) begin
        checks++;
        if (valid_m !== 1'b1 || bin_m !== pb || data_m !== pd) begin
          errors++;
          $display("[TB] FAIL stall_hold: valid=%b bin=%0d data=%h, required 1/%0d/%h",
                   valid_m, bin_m, data_m, pb, pd);
        end
      end
      case (mode)
        0:       r = 1'b1;
        1:       r = ((cyc % 2) == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      ready = r;
      if (noise) begin
        vsync = 1'($urandom_range(0, 1));
        de    = 1'($urandom_range(0, 1));
        bin   = CH*BB'($urandom);
      end
      if (valid_m === 1'b1 && r) begin
        checks++;
        if (bin_m !== BB'(idx) || last_m !== (idx == NB-1)) begin
          errors++;
          $display("[TB] FAIL word_order: bin=%0d last=%b, required %0d/%b", bin_m, last_m, idx, idx == NB-1);
        end
        checks++;
        if (valid_s !== 1'b1 || bin_s !== BB'(idx) || last_s !== (idx == NB-1)) begin
          errors++;
          $display("[TB] FAIL small_order: valid=%b bin=%0d last=%b, required 1/%0d/%b",
                   valid_s, bin_s, last_s, idx, idx == NB-1);
        end
        for (int k = 0; k < CH; k++) begin
          checks++;
          if (data_m[k*CW +: CW] !== CW'(exp_count(model[k][idx], CW))) begin
            errors++;
            $display("[TB] FAIL count ch%0d bin%0d: got %0d, required %0d", k, idx,
                     data_m[k*CW +: CW], exp_count(model[k][idx], CW));
          end
          checks++;
          if (data_s[k*SW +: SW] !== SW'(exp_count(model[k][idx], SW))) begin
            errors++;
            $display("[TB] FAIL small_count ch%0d bin%0d: got %0d, required %0d", k, idx,
                     data_s[k*SW +: SW], exp_count(model[k][idx], SW));
          end
        end
        if (idx == 0) begin
          checks++;
          if (ovf_m !== exp_ovf(CW) || ovf_s !== exp_ovf(SW)) begin
            errors++;
            $display("[TB] FAIL ovf: main=%b small=%b, required %b/%b", ovf_m, ovf_s, exp_ovf(CW), exp_ovf(SW));
          end
        end
        idx++;
      end
      prev_stall = (valid_m === 1'b1) && !r;
      pb = bin_m;
      pd = data_m;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (idx != NB) begin
      errors++;
      $display("[TB] FAIL readout_timeout: %0d words, required %0d", idx, NB);
    end
    vsync = 1'b0;
    de    = 1'b0;
    ready = 1'b1;
    checks++;
    if (valid_m !== 1'b0 || busy_m !== 1'b1) begin
      errors++;
      $display("[TB] FAIL after_last: valid=%b busy=%b, required 0/1", valid_m, busy_m);
    end
  endtask

  // Plays the queued pixels as one frame, closes it, and reads the histogram back.
  task automatic run_frame(input int mode, input bit noise);
    wait_idle();
    for (int k = 0; k < CH; k++)
      for (int b = 0; b < NB; b++)
        model[k][b] = 0;
    vsync = 1'b1;
    de    = 1'b1;
    bin   = CH*BB'($urandom);
    @(negedge clk);
    vsync = 1'b0;
    while (q_de.size() > 0) begin
      de  = q_de.pop_front();
      bin = q_bin.pop_front();
      if (de)
        for (int k = 0; k < CH; k++)
          model[k][bin[k*BB +: BB]]++;
      @(negedge clk);
    end
    vsync = 1'b1;
    de    = 1'b1;
    bin   = CH*BB'($urandom);
    @(negedge clk);
    vsync = 1'b0;
    de    = 1'b0;
    readout(mode, noise);
  endtask

  task automatic test_reset();
    int cnt;
    bit seen_valid;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy_m !== 1'b1 || valid_m !== 1'b0 || last_m !== 1'b0 || ovf_m !== 1'b0 ||
        bin_m !== '0 || data_m !== '0) begin
      errors++;
      $display("[TB] FAIL reset_values: busy=%b valid=%b last=%b ovf=%b bin=%0d data=%h, required 1/0/0/0/0/0",
               busy_m, valid_m, last_m, ovf_m, bin_m, data_m);
    end
    rst_n = 1'b1;
    #1;
    cnt = 0;
    seen_valid = 1'b0;
    while (busy_m === 1'b1 && cnt < 100) begin
      if (valid_m !== 1'b0) seen_valid = 1'b1;
      cnt++;
      @(negedge clk);
    end
    checks++;
    if (cnt != NB) begin
      errors++;
      $display("[TB] FAIL clear_length: busy high %0d cycles, required %0d", cnt, NB);
    end
    checks++;
    if (seen_valid) begin
      errors++;
      $display("[TB] FAIL clear_valid: valid=1 seen during CLEAR, required 0");
    end
  endtask

  task automatic test_single_bins();
    for (int i = 0; i < 100; i++) begin
      q_de.push_back(1'b1);
      q_bin.push_back(pack3(3, 7, 31));
    end
    run_frame(0, 1'b0);
  endtask

  task automatic test_forwarding();
    int b0 [9] = '{3, 3, 0, 3, 4, 3, 0, 0, 4};
    bit d0 [9] = '{1, 1, 0, 1, 1, 1, 0, 0, 1};
    for (int i = 0; i < 9; i++) begin
      q_de.push_back(d0[i]);
      q_bin.push_back(pack3(b0[i], $urandom_range(0, 1), $urandom_range(0, 31)));
    end
    run_frame(0, 1'b0);
  endtask

  task automatic test_ready_toggle();
    for (int i = 0; i < 80; i++) begin
      q_de.push_back(1'($urandom_range(0, 3) != 0));
      q_bin.push_back(CH*BB'($urandom));
    end
    run_frame(1, 1'b0);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 20; i++) begin
      q_de.push_back(1'b1);
      q_bin.push_back(pack3(0, 0, 0));
    end
    run_frame(0, 1'b0);
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 3; f++) begin
      int n;
      n = $urandom_range(50, 150);
      for (int i = 0; i < n; i++) begin
        q_de.push_back(1'($urandom_range(0, 1)));
        if (f == 1)
          q_bin.push_back(pack3($urandom_range(0, 1), $urandom_range(5, 6), $urandom_range(30, 31)));
        else
          q_bin.push_back(CH*BB'($urandom));
      end
      run_frame(2, 1'b1);
    end
  endtask

  task automatic test_reset_mid_accum();
    wait_idle();
    vsync = 1'b1;
    @(negedge clk);
    vsync = 1'b0;
    repeat (15) begin
      de  = 1'b1;
      bin = pack3(1, 1, 1);
      @(negedge clk);
    end
    #2;
    rst_n = 1'b0;
    de    = 1'b0;
    #1;
    checks++;
    if (busy_m !== 1'b1 || valid_m !== 1'b0 || ovf_m !== 1'b0 || bin_m !== '0 || data_m !== '0) begin
      errors++;
      $display("[TB] FAIL mid_reset: busy=%b valid=%b ovf=%b bin=%0d data=%h, required 1/0/0/0/0",
               busy_m, valid_m, ovf_m, bin_m, data_m);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      q_de.push_back(1'b1);
      q_bin.push_back(pack3(1, 1, 1));
    end
    run_frame(0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single_bins();
    test_forwarding();
    test_ready_toggle();
    test_overflow();
    test_random_frames();
    test_reset_mid_accum();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
